// File: rtl/fme_ctrl_pkg.sv
// Shared types, schedule constants and the lambda base lookup for fme_ctrl.
package fme_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  localparam int unsigned RUN_CYCLES = 54;
  localparam int unsigned INT_FIRST  = 1;
  localparam int unsigned INT_LAST   = 16;
  localparam int unsigned ORIG_FIRST = 5;
  localparam int unsigned ORIG_LAST  = 13;
  localparam int unsigned LAMBDA_N   = 6;

  // Offset of each lambda lane from the common base; element [0] is lane 0.
  localparam logic [LAMBDA_N-1:0][5:0] LAMBDA_OFS = {6'd41, 6'd34, 6'd27, 6'd14, 6'd7, 6'd0};
  localparam logic [5:0] LAMBDA_INIT_BASE = 6'd21;

  // Base index for the lambda lanes at a given RUN count.
  function automatic logic [5:0] lambda_base(input logic [5:0] cnt);
    logic [5:0] b;
    if (cnt <= 6'd16)      b = LAMBDA_INIT_BASE;
    else if (cnt <= 6'd26) b = 6'd3;
    else if (cnt == 6'd27) b = 6'd0;
    else if (cnt <= 6'd35) b = 6'd4;
    else if (cnt == 6'd36) b = 6'd1;
    else if (cnt <= 6'd44) b = 6'd5;
    else if (cnt == 6'd45) b = 6'd2;
    else                   b = 6'd6;
    return b;
  endfunction

endpackage

// File: rtl/fme_ctrl_if.sv
// Bus between fme_ctrl (master) and its host/fme/buffer environment (slave).
interface fme_ctrl_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic                   start;
  logic [DATAWIDTH+8:0]   ime_sad;
  logic [DATAWIDTH+8:0]   fme_best_sad;
  logic [5:0]             fme_best_addr;
  logic                   fme_clear;
  logic                   fme_enable;
  logic [DATAWIDTH+8:0]   best_sad_ime;
  logic                   int_vld;
  logic [3:0]             int_col;
  logic                   orig_vld;
  logic [2:0]             orig_col;
  logic [5:0]             lambda_addr_0;
  logic [5:0]             lambda_addr_1;
  logic [5:0]             lambda_addr_2;
  logic [5:0]             lambda_addr_3;
  logic [5:0]             lambda_addr_4;
  logic [5:0]             lambda_addr_5;
  logic                   busy;
  logic                   done;
  logic [DATAWIDTH+8:0]   res_sad;
  logic [5:0]             res_addr;

  modport master (
    input  start, ime_sad, fme_best_sad, fme_best_addr,
    output fme_clear, fme_enable, best_sad_ime, int_vld, int_col, orig_vld, orig_col,
           lambda_addr_0, lambda_addr_1, lambda_addr_2, lambda_addr_3, lambda_addr_4,
           lambda_addr_5, busy, done, res_sad, res_addr
  );

  modport slave (
    output start, ime_sad, fme_best_sad, fme_best_addr,
    input  fme_clear, fme_enable, best_sad_ime, int_vld, int_col, orig_vld, orig_col,
           lambda_addr_0, lambda_addr_1, lambda_addr_2, lambda_addr_3, lambda_addr_4,
           lambda_addr_5, busy, done, res_sad, res_addr
  );
endinterface

// File: rtl/fme_ctrl_lambda_sched.sv
// Maps the next RUN count to the six registered lambda*R buffer indices.
module fme_ctrl_lambda_sched
  import fme_ctrl_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      run_i,
  input  logic [5:0]                cnt_i,
  output logic [LAMBDA_N-1:0][5:0]  addr_o
);

  logic [LAMBDA_N-1:0][5:0] addr_d, addr_q;

  // Early counts read a contiguous window; later counts use base + lane offset.
  always_comb begin
    addr_d = '0;
    if (run_i) begin
      for (int unsigned i = 0; i < LAMBDA_N; i++) begin
        if (cnt_i <= 6'(INT_LAST)) addr_d[i] = LAMBDA_INIT_BASE + 6'(i);
        else                       addr_d[i] = lambda_base(cnt_i) + LAMBDA_OFS[i];
      end
    end
  end

  // Address register, cleared outside RUN.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/fme_ctrl.sv
// Sequencer for the fme datapath: clear, enable, buffer selects, drain, capture.
module fme_ctrl
  import fme_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH    = 8,
  parameter int unsigned DRAIN_CYCLES = 12
) (
  input  logic       clock,
  input  logic       reset,
  fme_ctrl_if.master bus
);

  localparam int unsigned SW = DATAWIDTH + 9;

  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [3:0] drain_q, drain_d;
  logic       run_d;
  logic       capture;

  logic          fme_clear_q, fme_clear_d;
  logic          fme_enable_q, fme_enable_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          int_vld_q, int_vld_d;
  logic [3:0]    int_col_q, int_col_d;
  logic          orig_vld_q, orig_vld_d;
  logic [2:0]    orig_col_q, orig_col_d;
  logic [SW-1:0] best_sad_ime_q, best_sad_ime_d;
  logic [SW-1:0] res_sad_q, res_sad_d;
  logic [5:0]    res_addr_q, res_addr_d;

  logic [LAMBDA_N-1:0][5:0] lambda_addr;

  // Next state, RUN count and drain count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        drain_d = '0;
        if (bus.start) state_d = ST_CLR;
      end
      ST_CLR: begin
        cnt_d   = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_q == 6'(RUN_CYCLES - 1)) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == 4'(DRAIN_CYCLES - 1)) begin
          state_d = ST_DONE;
          capture = 1'b1;
        end else begin
          drain_d = drain_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so they are derived from the next state and count.
  always_comb begin
    run_d          = (state_d == ST_RUN);
    fme_clear_d    = (state_d == ST_CLR);
    fme_enable_d   = run_d;
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
    int_vld_d      = 1'b0;
    int_col_d      = '0;
    orig_vld_d     = 1'b0;
    orig_col_d     = orig_col_q;
    best_sad_ime_d = best_sad_ime_q;
    res_sad_d      = res_sad_q;
    res_addr_d     = res_addr_q;
    if (run_d && cnt_d >= 6'(INT_FIRST) && cnt_d <= 6'(INT_LAST)) begin
      int_vld_d = 1'b1;
      int_col_d = 4'(cnt_d - 6'd1);
    end
    // Column 0 is presented twice (counts 5 and 6) before advancing.
    if (run_d && cnt_d >= 6'(ORIG_FIRST) && cnt_d <= 6'(ORIG_LAST)) begin
      orig_vld_d = 1'b1;
      orig_col_d = (cnt_d < 6'd6) ? 3'd0 : 3'(cnt_d - 6'd6);
    end
    if (state_q == ST_IDLE && bus.start) best_sad_ime_d = bus.ime_sad;
    if (capture) begin
      res_sad_d  = bus.fme_best_sad;
      res_addr_d = bus.fme_best_addr;
    end
  end

  // FSM state and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  // Output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fme_clear_q    <= 1'b0;
      fme_enable_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      int_vld_q      <= 1'b0;
      int_col_q      <= '0;
      orig_vld_q     <= 1'b0;
      orig_col_q     <= '0;
      best_sad_ime_q <= '1;
      res_sad_q      <= '0;
      res_addr_q     <= '0;
    end else begin
      fme_clear_q    <= fme_clear_d;
      fme_enable_q   <= fme_enable_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      int_vld_q      <= int_vld_d;
      int_col_q      <= int_col_d;
      orig_vld_q     <= orig_vld_d;
      orig_col_q     <= orig_col_d;
      best_sad_ime_q <= best_sad_ime_d;
      res_sad_q      <= res_sad_d;
      res_addr_q     <= res_addr_d;
    end
  end

  fme_ctrl_lambda_sched u_lambda (
    .clk_i  (clock),
    .rst_i  (reset),
    .run_i  (run_d),
    .cnt_i  (cnt_d),
    .addr_o (lambda_addr)
  );

  assign bus.fme_clear     = fme_clear_q;
  assign bus.fme_enable    = fme_enable_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.int_vld       = int_vld_q;
  assign bus.int_col       = int_col_q;
  assign bus.orig_vld      = orig_vld_q;
  assign bus.orig_col      = orig_col_q;
  assign bus.best_sad_ime  = best_sad_ime_q;
  assign bus.res_sad       = res_sad_q;
  assign bus.res_addr      = res_addr_q;
  assign bus.lambda_addr_0 = lambda_addr[0];
  assign bus.lambda_addr_1 = lambda_addr[1];
  assign bus.lambda_addr_2 = lambda_addr[2];
  assign bus.lambda_addr_3 = lambda_addr[3];
  assign bus.lambda_addr_4 = lambda_addr[4];
  assign bus.lambda_addr_5 = lambda_addr[5];

endmodule

// File: tb/tb_fme_ctrl.sv
// Directed self-checking bench for fme_ctrl.
module tb_fme_ctrl;
  import fme_ctrl_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  fme_ctrl_if #(.DATAWIDTH(8)) bus ();

  fme_ctrl #(.DATAWIDTH(8), .DRAIN_CYCLES(12)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [5:0] lam [6];
  assign lam[0] = bus.lambda_addr_0;
  assign lam[1] = bus.lambda_addr_1;
  assign lam[2] = bus.lambda_addr_2;
  assign lam[3] = bus.lambda_addr_3;
  assign lam[4] = bus.lambda_addr_4;
  assign lam[5] = bus.lambda_addr_5;

  int lam_cnt [5]    = '{0, 17, 27, 36, 53};
  int lam_exp [5][6] = '{'{21, 22, 23, 24, 25, 26},
                         '{3, 10, 17, 30, 37, 44},
                         '{0, 7, 14, 27, 34, 41},
                         '{1, 8, 15, 28, 35, 42},
                         '{6, 13, 20, 33, 40, 47}};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic test_reset();
    bus.ime_sad = 17'h00001;
    bus.start   = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.int_vld !== 1'b1) begin
      errors++; $display("FAIL reset_pre_int_vld got %b exp 1", bus.int_vld);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.fme_enable !== 1'b0 || bus.fme_clear !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got en=%b clr=%b busy=%b done=%b exp all 0",
               bus.fme_enable, bus.fme_clear, bus.busy, bus.done);
    end
    checks++;
    if (bus.int_vld !== 1'b0 || bus.int_col !== 4'd0 || bus.orig_vld !== 1'b0 || bus.orig_col !== 3'd0) begin
      errors++;
      $display("FAIL reset_cols got iv=%b ic=%0d ov=%b oc=%0d exp all 0",
               bus.int_vld, bus.int_col, bus.orig_vld, bus.orig_col);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (lam[i] !== 6'd0) begin
        errors++; $display("FAIL reset_lambda%0d got %0d exp 0", i, lam[i]);
      end
    end
    checks++;
    if (bus.best_sad_ime !== 17'h1FFFF) begin
      errors++; $display("FAIL reset_best_sad_ime got %h exp 1ffff", bus.best_sad_ime);
    end
    checks++;
    if (bus.res_sad !== 17'h0 || bus.res_addr !== 6'd0) begin
      errors++; $display("FAIL reset_res got %h/%0d exp 0/0", bus.res_sad, bus.res_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  // Full trace from start acceptance; assumes res_sad/res_addr are 0 on entry.
  task automatic test_nominal();
    int cnt;
    bus.ime_sad       = 17'h00FFF;
    bus.fme_best_sad  = 17'h1ABCD;
    bus.fme_best_addr = 6'd5;
    bus.start         = 1'b1;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clock);
      cnt = c - 2;
      checks++;
      if (bus.fme_clear !== (c == 1)) begin
        errors++; $display("FAIL nom_clear c=%0d got %b exp %b", c, bus.fme_clear, (c == 1));
      end
      checks++;
      if (bus.fme_enable !== (c >= 2 && c <= 55)) begin
        errors++; $display("FAIL nom_enable c=%0d got %b exp %b", c, bus.fme_enable, (c >= 2 && c <= 55));
      end
      checks++;
      if (bus.done !== (c == 68)) begin
        errors++; $display("FAIL nom_done c=%0d got %b exp %b", c, bus.done, (c == 68));
      end
      checks++;
      if (bus.busy !== (c <= 68)) begin
        errors++; $display("FAIL nom_busy c=%0d got %b exp %b", c, bus.busy, (c <= 68));
      end
      if (c <= 68) begin
        checks++;
        if (bus.best_sad_ime !== 17'h00FFF) begin
          errors++; $display("FAIL nom_best_sad_ime c=%0d got %h exp 00fff", c, bus.best_sad_ime);
        end
      end
      if (c >= 2 && c <= 55) begin
        if (cnt == 1 || cnt == 16) begin
          checks++;
          if (bus.int_vld !== 1'b1 || bus.int_col !== 4'(cnt - 1)) begin
            errors++; $display("FAIL int_col cnt=%0d got v=%b col=%0d exp v=1 col=%0d", cnt, bus.int_vld, bus.int_col, cnt - 1);
          end
        end
        if (cnt == 17) begin
          checks++;
          if (bus.int_vld !== 1'b0 || bus.int_col !== 4'd0) begin
            errors++; $display("FAIL int_end cnt=17 got v=%b col=%0d exp v=0 col=0", bus.int_vld, bus.int_col);
          end
        end
        if (cnt == 5 || cnt == 6) begin
          checks++;
          if (bus.orig_vld !== 1'b1 || bus.orig_col !== 3'd0) begin
            errors++; $display("FAIL orig_first cnt=%0d got v=%b col=%0d exp v=1 col=0", cnt, bus.orig_vld, bus.orig_col);
          end
        end
        if (cnt == 13) begin
          checks++;
          if (bus.orig_vld !== 1'b1 || bus.orig_col !== 3'd7) begin
            errors++; $display("FAIL orig_last cnt=13 got v=%b col=%0d exp v=1 col=7", bus.orig_vld, bus.orig_col);
          end
        end
        if (cnt == 14) begin
          checks++;
          if (bus.orig_vld !== 1'b0 || bus.orig_col !== 3'd7) begin
            errors++; $display("FAIL orig_end cnt=14 got v=%b col=%0d exp v=0 col=7", bus.orig_vld, bus.orig_col);
          end
        end
        for (int k = 0; k < 5; k++) begin
          if (cnt == lam_cnt[k]) begin
            for (int i = 0; i < 6; i++) begin
              checks++;
              if (lam[i] !== 6'(lam_exp[k][i])) begin
                errors++; $display("FAIL lambda cnt=%0d lane=%0d got %0d exp %0d", cnt, i, lam[i], lam_exp[k][i]);
              end
            end
          end
        end
      end
      if (c == 56) begin
        checks++;
        if (lam[5] !== 6'd0 || lam[0] !== 6'd0) begin
          errors++; $display("FAIL lambda_idle c=56 got %0d/%0d exp 0/0", lam[0], lam[5]);
        end
      end
      if (c == 67) begin
        checks++;
        if (bus.res_sad !== 17'h0 || bus.res_addr !== 6'd0) begin
          errors++; $display("FAIL res_early c=67 got %h/%0d exp 0/0", bus.res_sad, bus.res_addr);
        end
      end
      if (c >= 68) begin
        checks++;
        if (bus.res_sad !== 17'h00123 || bus.res_addr !== 6'd42) begin
          errors++; $display("FAIL res_capture c=%0d got %h/%0d exp 00123/42", c, bus.res_sad, bus.res_addr);
        end
      end
      bus.start = (c == 30);
      if (c == 1) bus.ime_sad = 17'h0AAAA;
      if (c == 67) begin
        bus.fme_best_sad  = 17'h00123;
        bus.fme_best_addr = 6'd42;
      end
      if (c == 68) begin
        bus.fme_best_sad  = 17'h1ABCD;
        bus.fme_best_addr = 6'd5;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_back_to_back();
    bus.ime_sad = 17'h00FFF;
    bus.start   = 1'b1;
    for (int c = 1; c <= 71; c++) begin
      @(negedge clock);
      if (c == 68) begin
        checks++;
        if (bus.done !== 1'b1) begin
          errors++; $display("FAIL b2b_done c=68 got %b exp 1", bus.done);
        end
      end
      if (c == 69) begin
        checks++;
        if (bus.busy !== 1'b0 || bus.fme_clear !== 1'b0) begin
          errors++; $display("FAIL b2b_idle c=69 got busy=%b clr=%b exp 0/0", bus.busy, bus.fme_clear);
        end
      end
      if (c == 70) begin
        checks++;
        if (bus.fme_clear !== 1'b1 || bus.busy !== 1'b1) begin
          errors++; $display("FAIL b2b_restart c=70 got clr=%b busy=%b exp 1/1", bus.fme_clear, bus.busy);
        end
      end
      if (c == 71) begin
        checks++;
        if (bus.fme_enable !== 1'b1) begin
          errors++; $display("FAIL b2b_enable c=71 got %b exp 1", bus.fme_enable);
        end
      end
    end
    bus.start = 1'b0;
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_midrun_reset();
    bus.ime_sad = 17'h00FFF;
    bus.start   = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.fme_enable !== 1'b1) begin
      errors++; $display("FAIL mid_pre_enable got %b exp 1", bus.fme_enable);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus.fme_enable !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl got en=%b busy=%b exp 0/0", bus.fme_enable, bus.busy);
    end
    checks++;
    if (dut.state_q !== ST_IDLE) begin
      errors++; $display("FAIL mid_reset_state got %0d exp %0d", dut.state_q, ST_IDLE);
    end
    checks++;
    if (lam[0] !== 6'd0 || bus.int_vld !== 1'b0) begin
      errors++; $display("FAIL mid_reset_sel got lam0=%0d iv=%b exp 0/0", lam[0], bus.int_vld);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_nominal();
  endtask

  initial begin
    checks            = 0;
    errors            = 0;
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.ime_sad       = '0;
    bus.fme_best_sad  = '0;
    bus.fme_best_addr = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    test_reset();
    test_nominal();
    test_back_to_back();
    test_midrun_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fme_ctrl.md
# fme_ctrl

Sequencer for the `fme` fractional motion estimation datapath. On `start` it clears the datapath and drives `enable`, and it generates the per-cycle read selects for the integer-pixel, original-block and lambda·R buffers. After the pipeline drains, it latches `best_sad` and `address_best_sad` and pulses `done`. It sits between the motion-estimation top level (after IME) and one `fme` instance.

## Interface
- `DATAWIDTH`, 8, pixel width; SAD width is DATAWIDTH+9.
- `DRAIN_CYCLES`, 12, cycles between `fme_enable` falling and result capture.
- The clock is `clock` and the reset is `reset`. There is one clock; reset is asynchronous and active-high.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `ime_sad`  in  DATAWIDTH+9  best IME SAD; captured at start acceptance.
- `fme_best_sad`  in  DATAWIDTH+9  from `fme.best_sad`.
- `fme_best_addr`  in  6  from `fme.address_best_sad`.
- `fme_clear`  out  1  one-cycle reset pulse to `fme`.
- `fme_enable`  out  1  to `fme.enable`.
- `best_sad_ime`  out  DATAWIDTH+9  held IME SAD to `fme`.
- `int_vld`  out  1  integer-column select valid.
- `int_col`  out  4  integer-pixel column k; the buffer drives `in_r = pix[k+16r]`.
- `orig_vld`  out  1  original-column select valid.
- `orig_col`  out  3  original column c; the buffer drives `original_r = orig[c+8r]`.
- `lambda_addr_0..5`  out  6 each  lambda·R buffer indices feeding `lambda_r_SAD_0..5`.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse when the result is valid.
- `res_sad`  out  DATAWIDTH+9  latched best SAD.
- `res_addr`  out  6  latched best address.

## Operation
- The FSM has five states: IDLE → CLR → RUN → DRAIN → DONE → IDLE.
- **IDLE**
  - `start` high moves to CLR.
  - `ime_sad` is captured into `best_sad_ime`.
- **CLR** lasts one cycle and asserts `fme_clear`.
- **RUN** lasts 54 cycles.
  - Run counter `cnt` runs 0..53.
  - `fme_enable` is high throughout.
- **DRAIN** lasts DRAIN_CYCLES cycles, with `fme_enable` low.
  - On the edge leaving the last DRAIN cycle, `res_sad` captures `fme_best_sad` and `res_addr` captures `fme_best_addr`.
- **DONE** lasts one cycle, with `done` high.
- Integer columns:
  - `int_vld` is high for cnt 1..16, with `int_col = cnt-1`.
  - Otherwise `int_vld` is 0 and `int_col` is 0.
- Original columns:
  - `orig_vld` is high for cnt 5..13, with `orig_col = max(cnt-6, 0)`. Column 0 is therefore presented at cnt 5 and 6.
  - Otherwise `orig_vld` is 0 and `orig_col` holds its last value.
- Lambda schedule, with offsets O = {0,7,14,27,34,41}:
  - cnt 0..16: addresses 21..26, contiguous.
  - Otherwise base b is 3 for cnt 17..26, 0 at 27, 4 for 28..35, 1 at 36, 5 for 37..44, 2 at 45, and 6 for 46..53.
  - `lambda_addr_i = b + O[i]`.
  - Outside RUN the addresses are 0.
- `start` outside IDLE is ignored, with no queuing.
- `busy` is high from CLR through DONE.
- Reset mid-operation clears every register asynchronously and returns to IDLE. The datapath stops at once because `fme_enable` goes to 0.
- Width rules:
  - `cnt` is 6 bits and saturates in RUN.
  - The drain counter is 4 bits.
  - No arithmetic overflow is possible, because the maximum address is 6+41 = 47.

## Timing
- All outputs are registered and change only on a rising edge.
- Reset values:
  - `best_sad_ime` is all ones (17'h1FFFF at DATAWIDTH = 8).
  - Every other output is 0, and the FSM is in IDLE.
- Selects are valid in the same cycle that `fme` samples the corresponding data, so the buffers are asynchronous-read.
- Cycle counts are relative to the edge that accepts `start`:
  - CLR is cycle 1.
  - RUN occupies cycles 2..55.
  - DRAIN occupies cycles 56..(55+DRAIN_CYCLES).
  - `done` is high at cycle 56+DRAIN_CYCLES, which is 68 by default.
- `res_sad` and `res_addr` hold their values until the next capture.
- The earliest next start is accepted in the cycle after DONE (IDLE), so the minimum issue interval is 69 cycles.

## Structure
- `fme_ctrl_pkg` holds:
  - the state enum;
  - RUN_CYCLES = 54;
  - INT_FIRST/LAST = 1/16;
  - ORIG_FIRST/LAST = 5/13;
  - the lambda offset array O;
  - the initial lambda base of 21;
  - function `lambda_base(cnt)`.
- Sub-module `fme_ctrl_lambda_sched` maps `cnt` to the six registered lambda addresses. The FSM, counters and capture logic stay in `fme_ctrl`.

## Test plan
- **Reset:** assert `reset` asynchronously between edges.
  - Outputs go to 0 immediately, `best_sad_ime` goes to 17'h1FFFF, and `busy` is 0.
- **Nominal run:** `start` with `ime_sad` = 17'h00FFF.
  - `fme_clear` is high at cycle 1 only.
  - `fme_enable` is high for cycles 2..55.
  - `done` is high at cycle 68 only.
  - `best_sad_ime` is 0x00FFF throughout.
- **Column selects:**
  - At cnt 1: `int_col` = 0 with `int_vld`.
  - At cnt 16: `int_col` = 15.
  - At cnt 17: `int_vld` = 0.
  - At cnt 5 and 6: `orig_col` = 0.
  - At cnt 13: `orig_col` = 7.
  - At cnt 14: `orig_vld` = 0.
- **Lambda trace:**
  - cnt 0: 21..26.
  - cnt 17: 3,10,17,30,37,44.
  - cnt 27: 0,7,14,27,34,41.
  - cnt 36: 1,8,15,28,35,42.
  - cnt 53: 6,13,20,33,40,47.
- **Capture and handshake:**
  - Model drives `fme_best_sad` = 0x00123 and `fme_best_addr` = 42 at the end of DRAIN. `res_sad` = 0x00123 and `res_addr` = 42 are seen in DONE and held afterwards.
  - `start` pulsed at cycle 30 is ignored.
  - `start` held high restarts at cycle 69.
- **Mid-run reset:** assert `reset` at cnt 30.
  - `fme_enable` drops immediately and the FSM is in IDLE.
  - A following `start` produces the full nominal trace.
